// File: rtl/conv_fmap_streamer.sv
// Buffers N_CH feature maps and streams them pixel-per-cycle, all channels in lockstep.
// Define ZERO_PAD_EN to stream each map with a one-pixel zero border.
module conv_fmap_streamer #(
    parameter int DATA_W = 32,
    parameter int IMG_H  = 12,
    parameter int IMG_W  = 12,
    parameter int N_CH   = 6,
    parameter int ADDR_W = 8
) (
    input  logic              clk_global,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              pause,
    input  logic              conv_finish,
    output logic [DATA_W-1:0] image_kernal_1,
    output logic [DATA_W-1:0] image_kernal_2,
    output logic [DATA_W-1:0] image_kernal_3,
    output logic [DATA_W-1:0] image_kernal_4,
    output logic [DATA_W-1:0] image_kernal_5,
    output logic [DATA_W-1:0] image_kernal_6,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);
    localparam int DEPTH = IMG_H * IMG_W;
`ifdef ZERO_PAD_EN
    localparam int FRAME_H = IMG_H + 2;
    localparam int FRAME_W = IMG_W + 2;
`else
    localparam int FRAME_H = IMG_H;
    localparam int FRAME_W = IMG_W;
`endif
    localparam int ROW_W = $clog2(FRAME_H);
    localparam int COL_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_FIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] kern_q [N_CH];
    logic [DATA_W-1:0] kern_d [N_CH];
    logic [DATA_W-1:0] mem_q  [N_CH][DEPTH];

    logic              wr_ok_s;
    logic              rd_issue_s;
    logic              border_s;
    logic              row_last_s;
    logic              col_last_s;
    logic [ROW_W-1:0]  src_row_s;
    logic [COL_W-1:0]  src_col_s;
    logic [ADDR_W-1:0] rd_addr_s;

    assign row_last_s = (row_q == ROW_W'(FRAME_H - 1));
    assign col_last_s = (col_q == COL_W'(FRAME_W - 1));

`ifdef ZERO_PAD_EN
    // Frame position (r+1,c+1) maps to stored pixel (r,c); the ring is zero.
    assign border_s  = (row_q == '0) || row_last_s || (col_q == '0) || col_last_s;
    assign src_row_s = row_q - ROW_W'(1);
    assign src_col_s = col_q - COL_W'(1);
`else
    assign border_s  = 1'b0;
    assign src_row_s = row_q;
    assign src_col_s = col_q;
`endif

    assign rd_addr_s = ADDR_W'(src_row_s) * ADDR_W'(IMG_W) + ADDR_W'(src_col_s);

    // The extra address bit keeps the range check correct when DEPTH == 2**ADDR_W.
    assign wr_ok_s = wr_en && (state_q == ST_IDLE) && (wr_ch < 3'(N_CH))
                     && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));

    // Next-state, raster position and status pulses.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        rd_issue_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (!pause) begin
                    rd_issue_s = 1'b1;
                    valid_d    = 1'b1;
                    if (col_last_s) begin
                        col_d = '0;
                        if (row_last_s) begin
                            row_d   = '0;
                            state_d = ST_WAIT_FIN;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT_FIN: begin
                if (conv_finish) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d   = (state_d != ST_IDLE);
        wr_err_d = wr_en && !wr_ok_s;
    end

    // Synchronous buffer read; idle and border beats carry zero.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            if (rd_issue_s && !border_s) begin
                kern_d[k] = mem_q[k][rd_addr_s];
            end else begin
                kern_d[k] = '0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_global) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                kern_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            for (int k = 0; k < N_CH; k++) begin
                kern_q[k] <= kern_d[k];
            end
        end
    end

    // Feature-map storage; contents survive reset.
    always_ff @(posedge clk_global) begin
        if (reset && wr_ok_s) begin
            mem_q[wr_ch][wr_addr] <= wr_data;
        end
    end

    assign image_kernal_1 = kern_q[0];
    assign image_kernal_2 = kern_q[1];
    assign image_kernal_3 = kern_q[2];
    assign image_kernal_4 = kern_q[3];
    assign image_kernal_5 = kern_q[4];
    assign image_kernal_6 = kern_q[5];
    assign valid          = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign wr_err         = wr_err_q;
endmodule

// File: tb/tb_conv_fmap_streamer.sv
// Self-checking bench for conv_fmap_streamer: write-rule table, directed frame scenarios,
// randomized frames, all compared cycle by cycle against a frame-level reference model.
module tb_conv_fmap_streamer;
    localparam int DW    = 32;
    localparam int H     = 12;
    localparam int W     = 12;
    localparam int NC    = 6;
    localparam int AW    = 8;
    localparam int DEPTH = H * W;
`ifdef ZERO_PAD_EN
    localparam int FH = H + 2;
    localparam int FW = W + 2;
`else
    localparam int FH = H;
    localparam int FW = W;
`endif
    localparam int FRAME = FH * FW;

    logic          clk_global = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = 3'd0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          conv_finish = 1'b0;
    logic [DW-1:0] k1, k2, k3, k4, k5, k6;
    logic          valid, busy, done, wr_err;
    logic [DW-1:0] kout [NC];

    assign kout[0] = k1;
    assign kout[1] = k2;
    assign kout[2] = k3;
    assign kout[3] = k4;
    assign kout[4] = k5;
    assign kout[5] = k6;

    always #5 clk_global = ~clk_global;

    conv_fmap_streamer dut (
        .clk_global     (clk_global),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_ch          (wr_ch),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .pause          (pause),
        .conv_finish    (conv_finish),
        .image_kernal_1 (k1),
        .image_kernal_2 (k2),
        .image_kernal_3 (k3),
        .image_kernal_4 (k4),
        .image_kernal_5 (k5),
        .image_kernal_6 (k6),
        .valid          (valid),
        .busy           (busy),
        .done           (done),
        .wr_err         (wr_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int cyc = 0;

    // Reference model: frame buffer plus phase (0 idle, 1 streaming, 2 awaiting finish).
    logic [DW-1:0] model_mem [NC][DEPTH];
    int m_phase = 0;
    int m_pos = 0;

    typedef struct {
        logic          we;
        logic [2:0]    ch;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_err;
    } wvec_t;
    wvec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_pix(input int k, input int pos);
        int r;
        int c;
        r = pos / FW;
        c = pos % FW;
`ifdef ZERO_PAD_EN
        if (r == 0 || r == FH - 1 || c == 0 || c == FW - 1) return '0;
        return model_mem[k][(r - 1) * W + (c - 1)];
`else
        return model_mem[k][r * W + c];
`endif
    endfunction

    // Advance the model over one edge with the current inputs, then compare every output.
    task automatic tick();
        logic [DW-1:0] ep [NC];
        bit ev;
        bit ed;
        bit ee;
        ev = 1'b0;
        ed = 1'b0;
        ee = 1'b0;
        for (int k = 0; k < NC; k++) ep[k] = '0;
        if (!reset) begin
            m_phase = 0;
            m_pos = 0;
        end else begin
            if (wr_en) begin
                if (m_phase == 0 && wr_ch < NC && wr_addr < DEPTH)
                    model_mem[wr_ch][wr_addr] = wr_data;
                else
                    ee = 1'b1;
            end
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_pos = 0;
                end
                1: if (!pause) begin
                    ev = 1'b1;
                    for (int k = 0; k < NC; k++) ep[k] = exp_pix(k, m_pos);
                    m_pos++;
                    if (m_pos == FRAME) m_phase = 2;
                end
                2: if (conv_finish) begin
                    m_phase = 0;
                    ed = 1'b1;
                end
                default: ;
            endcase
        end
        @(posedge clk_global);
        #1;
        cyc++;
        check("valid", valid, ev);
        check("busy", busy, (m_phase != 0));
        check("done", done, ed);
        check("wr_err", wr_err, ee);
        for (int k = 0; k < NC; k++) check($sformatf("kern%0d", k + 1), kout[k], ep[k]);
        if (valid === 1'b1) n_valid++;
    endtask

    task automatic run_frame(input int pause_after, input int pause_len, input int fin_delay,
                             input int poke_at, input int reset_at, input bit rnd);
        int base;
        int seen;
        int pcnt;
        int budget;
        bit paused_once;
        bit poked;
        bit aborted;
        base = n_valid;
        pcnt = 0;
        budget = 0;
        paused_once = 1'b0;
        poked = 1'b0;
        aborted = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        while (m_phase == 1 && budget < 4 * FRAME) begin
            seen = n_valid - base;
            pause = 1'b0;
            wr_en = 1'b0;
            start = 1'b0;
            conv_finish = 1'b0;
            if (pause_after >= 0 && !paused_once && seen == pause_after) begin
                pcnt = pause_len;
                paused_once = 1'b1;
            end
            if (pcnt > 0) begin
                pause = 1'b1;
                pcnt--;
            end
            if (!poked && poke_at >= 0 && seen == poke_at) begin
                poked = 1'b1;
                wr_en = 1'b1;
                wr_ch = 3'($urandom_range(0, NC - 1));
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_data = $urandom;
            end
            if (rnd) begin
                pause = pause | ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 15) == 0);
                conv_finish = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    wr_en = 1'b1;
                    wr_ch = 3'($urandom_range(0, 7));
                    wr_addr = AW'($urandom_range(0, DEPTH + 5));
                    wr_data = $urandom;
                end
            end
            if (reset_at >= 0 && seen == reset_at) begin
                pause = 1'b0;
                wr_en = 1'b0;
                reset = 1'b0;
                tick();
                reset = 1'b1;
                aborted = 1'b1;
                check("abort_valid", valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_k1", k1, 0);
            end else begin
                tick();
            end
            budget++;
        end
        pause = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        conv_finish = 1'b0;
        if (budget >= 4 * FRAME) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d valid beats, expected %0d", n_valid - base, FRAME);
        end else if (!aborted) begin
            check("frame_len", n_valid - base, FRAME);
            for (int d = 0; d < fin_delay; d++) begin
                start = (d == 0);
                tick();
                check("busy_hold", busy, 1);
            end
            start = 1'b0;
            conv_finish = 1'b1;
            tick();
            conv_finish = 1'b0;
            check("done_pulse", done, 1);
            check("busy_clear", busy, 0);
            tick();
            check("done_once", done, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_k6", k6, 0);
        reset = 1'b1;

        tbl[0] = '{1'b1, 3'd0, 8'd0,   32'h0000_1111, 1'b0};
        tbl[1] = '{1'b1, 3'd5, 8'd143, 32'h0005_2222, 1'b0};
        tbl[2] = '{1'b1, 3'd6, 8'd0,   32'hDEAD_0001, 1'b1};
        tbl[3] = '{1'b1, 3'd7, 8'd5,   32'hDEAD_0002, 1'b1};
        tbl[4] = '{1'b1, 3'd2, 8'd144, 32'hDEAD_0003, 1'b1};
        tbl[5] = '{1'b1, 3'd3, 8'd255, 32'hDEAD_0004, 1'b1};
        tbl[6] = '{1'b0, 3'd6, 8'd200, 32'hDEAD_0005, 1'b0};
        tbl[7] = '{1'b1, 3'd4, 8'd17,  32'h0004_3333, 1'b0};
        for (int v = 0; v < 8; v++) begin
            wr_en = tbl[v].we;
            wr_ch = tbl[v].ch;
            wr_addr = tbl[v].addr;
            wr_data = tbl[v].data;
            tick();
            check($sformatf("tbl_err%0d", v), wr_err, tbl[v].exp_err);
        end
        wr_en = 1'b0;

        for (int k = 0; k < NC; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr_en = 1'b1;
                wr_ch = 3'(k);
                wr_addr = AW'(i);
                wr_data = (DW'(k) << 16) | DW'(i);
                tick();
            end
        end
        wr_en = 1'b0;

        run_frame(-1, 0, 0, -1, -1, 1'b0);
        run_frame(10, 3, 1, -1, -1, 1'b0);
        run_frame(-1, 0, 2, 20, -1, 1'b0);
        wr_en = 1'b1; wr_ch = 3'd6; wr_addr = 8'd3; wr_data = 32'hBAD0_0006;
        tick();
        check("bad_ch_err", wr_err, 1);
        wr_ch = 3'd1; wr_addr = 8'd144; wr_data = 32'hBAD0_0144;
        tick();
        check("bad_addr_err", wr_err, 1);
        wr_en = 1'b0;
        tick();
        check("err_once", wr_err, 0);
        run_frame(-1, 0, 0, -1, -1, 1'b0);
        run_frame(-1, 0, 5, -1, -1, 1'b0);
        run_frame(-1, 0, 0, -1, 50, 1'b0);
        run_frame(-1, 0, 0, -1, -1, 1'b0);
        run_frame(FRAME - 1, 2, 0, -1, -1, 1'b0);

        wr_en = 1'b1; wr_ch = 3'd0; wr_addr = 8'd0; wr_data = 32'hABCD_0123;
        run_frame(-1, 0, 1, -1, -1, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 12; j++) begin
                wr_en = ($urandom_range(0, 3) != 0);
                wr_ch = 3'($urandom_range(0, 7));
                wr_addr = AW'($urandom_range(0, DEPTH + 5));
                wr_data = $urandom;
                pause = $urandom_range(0, 1) == 1;
                conv_finish = ($urandom_range(0, 7) == 0);
                tick();
            end
            pause = 1'b0;
            conv_finish = 1'b0;
            wr_en = ($urandom_range(0, 1) == 1);
            wr_ch = 3'($urandom_range(0, NC - 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            run_frame(-1, 0, int'($urandom_range(0, 6)), -1, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
